vp_pixel_serializer: RTL

- Downstream neighbour of the bitmap-to-pixels stage: accepts 64-bit words of sixteen 4-bit colour indices, qualified by `enable`.
- Buffers words in a small FIFO and emits one 4-bit pixel per pixel-clock strobe to the palette/DAC stage.
- Absorbs jitter between the character pipeline and video timing, and flags underflow/overflow for debug.

---
 rtl/vp_pixel_serializer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/vp_pixel_serializer.sv
// rtl/vp_pixel_serializer.sv - word FIFO plus shift register emitting one 4-bit pixel per pixel strobe
//
// Accepts 64-bit words of sixteen colour indices ([63:60] first on screen),
// buffers them in a DEPTH-word FIFO and shifts them out one pixel per
// active pixel strobe. Underflow/overflow are sticky debug flags.
//
// Optional build macro: VP_PIXEL_DOUBLE_EN adds input double_width, which
// holds each pixel for two active strobes.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-low reset
//   pixels         in   64-bit word of 16 pixels
//   enable         in   one-cycle write strobe for pixels
//   ready          out  FIFO occupancy < DEPTH (advisory)
//   pixel_strobe   in   pixel-clock enable
//   display_active in   visible area, qualifies consumption
//   flush          in   synchronous clear of FIFO and shift register
//   clear_errors   in   clears sticky flags
//   pixel          out  registered colour index
//   pixel_valid    out  pixel came from a real word this strobe
//   level          out  FIFO word occupancy
//   underflow      out  sticky: active strobe with no pixel available
//   overflow       out  sticky: write dropped because FIFO full
//   double_width   in   (VP_PIXEL_DOUBLE_EN only) hold each pixel two strobes

module vp_pixel_serializer #(
    parameter int         DEPTH    = 4,
    parameter logic [3:0] BG_INDEX = 4'd0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [63:0]                pixels,
    input  logic                       enable,
    output logic                       ready,
    input  logic                       pixel_strobe,
    input  logic                       display_active,
    input  logic                       flush,
    input  logic                       clear_errors,
    output logic [3:0]                 pixel,
    output logic                       pixel_valid,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       underflow,
`ifdef VP_PIXEL_DOUBLE_EN
    input  logic                       double_width,
`endif
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [63:0]   r_sr;
    logic [4:0]    r_rem;
    logic          r_half;
    logic [3:0]    r_pixel;
    logic          r_pixel_valid;
    logic          r_underflow;
    logic          r_overflow;

    logic          w_dbl;
    logic          w_empty;
    logic          w_full;
    logic          w_active;
    logic          w_push;
    logic          w_pop;
    logic          w_emit;
    logic [3:0]    w_emit_pix;
    logic [63:0]   w_head;
    logic [63:0]   w_sr_nxt;
    logic [4:0]    w_rem_nxt;
    logic          w_half_nxt;
    logic          w_uf_set;
    logic          w_of_set;

`ifdef VP_PIXEL_DOUBLE_EN
    assign w_dbl = double_width;
`else
    assign w_dbl = 1'b0;
`endif

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == LW'(DEPTH));
    assign w_active = pixel_strobe & display_active & ~flush;
    assign w_head   = r_mem[r_rd_ptr];
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push   = enable & ~flush & (~w_full | w_pop);
    assign w_of_set = enable & ~flush & w_full & ~w_pop;

    always_comb begin
        w_pop      = 1'b0;
        w_emit     = 1'b0;
        w_emit_pix = r_sr[63:60];
        w_sr_nxt   = r_sr;
        w_rem_nxt  = r_rem;
        w_half_nxt = r_half;
        w_uf_set   = 1'b0;
        if (w_active) begin
            if (r_rem != 5'd0) begin
                w_emit = 1'b1;
                // r_half marks that the first of two strobes has been shown;
                // a shift only happens at a pixel boundary, so toggling
                // double_width mid-pixel finishes the current pixel first.
                if (w_dbl && !r_half) begin
                    w_half_nxt = 1'b1;
                end else begin
                    w_half_nxt = 1'b0;
                    if (r_rem == 5'd1 && !w_empty) begin
                        // Reload on the last pixel for gapless output.
                        w_pop     = 1'b1;
                        w_sr_nxt  = w_head;
                        w_rem_nxt = 5'd16;
                    end else begin
                        w_sr_nxt  = {r_sr[59:0], 4'h0};
                        w_rem_nxt = r_rem - 5'd1;
                    end
                end
            end else if (!w_empty) begin
                w_pop      = 1'b1;
                w_emit     = 1'b1;
                w_emit_pix = w_head[63:60];
                if (w_dbl) begin
                    w_sr_nxt   = w_head;
                    w_rem_nxt  = 5'd16;
                    w_half_nxt = 1'b1;
                end else begin
                    w_sr_nxt   = {w_head[59:0], 4'h0};
                    w_rem_nxt  = 5'd15;
                    w_half_nxt = 1'b0;
                end
            end else begin
                w_uf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pixels;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_sr          <= '0;
            r_rem         <= 5'd0;
            r_half        <= 1'b0;
            r_pixel       <= BG_INDEX;
            r_pixel_valid <= 1'b0;
            r_underflow   <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_level       <= '0;
                r_sr          <= '0;
                r_rem         <= 5'd0;
                r_half        <= 1'b0;
                r_pixel       <= BG_INDEX;
                r_pixel_valid <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LW'(1);
                    2'b01:   r_level <= r_level - LW'(1);
                    default: r_level <= r_level;
                endcase
                r_sr   <= w_sr_nxt;
                r_rem  <= w_rem_nxt;
                r_half <= w_half_nxt;
                if (pixel_strobe) begin
                    r_pixel       <= w_emit ? w_emit_pix : BG_INDEX;
                    r_pixel_valid <= w_emit;
                end else begin
                    r_pixel_valid <= 1'b0;
                end
            end
            // A new error in the same cycle as clear_errors wins.
            r_underflow <= (r_underflow & ~clear_errors) | w_uf_set;
            r_overflow  <= (r_overflow  & ~clear_errors) | w_of_set;
        end
    end

    assign ready       = ~w_full;
    assign level       = r_level;
    assign pixel       = r_pixel;
    assign pixel_valid = r_pixel_valid;
    assign underflow   = r_underflow;
    assign overflow    = r_overflow;

endmodule
